// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: serialises CPU 8/16/32-bit loads/stores onto a byte bus.
// Optional: define DATA_MEM_MISALIGN_CHK_EN to reject misaligned half/word.
module data_mem_ctrl #(
  parameter int LEN        = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int BYTE_SIZE  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_vis_enabled,
  input  logic [1:0]            memory_vis_signal,
  input  logic [1:0]            mem_size,
  input  logic                  mem_sign_ext,
  input  logic [ADDR_WIDTH-1:0] mem_data_addr,
  input  logic [LEN-1:0]        mem_write_data,
  output logic [LEN-1:0]        mem_read_data,
  output logic [1:0]            mem_vis_status,
  output logic [ADDR_WIDTH-1:0] mem_vis_addr,
  output logic [1:0]            mem_vis_signal,
  output logic [BYTE_SIZE-1:0]  writen_data,
  input  logic [BYTE_SIZE-1:0]  mem_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t                r_state, w_state;
  logic [2:0]            r_cnt, w_cnt, w_nxt;
  logic [2:0]            r_n, w_nin;
  logic [ADDR_WIDTH-1:0] r_base, w_off;
  logic [LEN-1:0]        r_wdata;
  logic [LEN-1:0]        r_rbuf, w_rbuf, w_ext;
  logic                  r_sext;
  logic                  w_acc, w_sgn;
  logic [1:0]            w_bidx;
  logic [1:0]            w_status, w_sig;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [BYTE_SIZE-1:0]  w_wdat;
  logic [LEN-1:0]        w_rdata;
`ifdef DATA_MEM_MISALIGN_CHK_EN
  logic                  w_mis;
`endif

  function automatic logic [BYTE_SIZE-1:0] byte_of(
    input logic [LEN-1:0] d,
    input logic [1:0]     k
  );
    byte_of = d[k*BYTE_SIZE +: BYTE_SIZE];
  endfunction

  assign w_acc = mem_vis_enabled &&
    (memory_vis_signal == 2'b01 || memory_vis_signal == 2'b10);
  assign w_nxt  = r_cnt + 3'd1;
  assign w_off  = {{(ADDR_WIDTH-3){1'b0}}, w_nxt};
  assign w_bidx = 2'(r_cnt - 3'd1);

`ifdef DATA_MEM_MISALIGN_CHK_EN
  assign w_mis =
    (mem_size == 2'b01 && mem_data_addr[0]) ||
    (mem_size[1] && mem_data_addr[1:0] != 2'b00);
`endif

  always_comb begin
    w_nin = 3'd4;
    unique case (mem_size)
      2'b00:   w_nin = 3'd1;
      2'b01:   w_nin = 3'd2;
      default: w_nin = 3'd4;
    endcase
  end

  // byte j-1 arrives while the counter reads j
  always_comb begin
    w_rbuf = r_rbuf;
    if (r_state == S_READ && r_cnt != 3'd0)
      w_rbuf[w_bidx*BYTE_SIZE +: BYTE_SIZE] = mem_data;
  end

  always_comb begin
    w_sgn = 1'b0;
    w_ext = w_rbuf;
    unique case (r_n)
      3'd1: begin
        w_sgn = r_sext & w_rbuf[BYTE_SIZE-1];
        w_ext = {{(LEN-BYTE_SIZE){w_sgn}},
                 w_rbuf[BYTE_SIZE-1:0]};
      end
      3'd2: begin
        w_sgn = r_sext & w_rbuf[2*BYTE_SIZE-1];
        w_ext = {{(LEN-2*BYTE_SIZE){w_sgn}},
                 w_rbuf[2*BYTE_SIZE-1:0]};
      end
      default: w_ext = w_rbuf;
    endcase
  end

  // next-cycle values; every output is registered from these
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_status = 2'b00;
    w_sig    = 2'b00;
    w_addr   = '0;
    w_wdat   = '0;
    w_rdata  = mem_read_data;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
`ifdef DATA_MEM_MISALIGN_CHK_EN
          if (w_mis) begin
            w_state  = S_ERR;
            w_status = 2'b11;
          end else
`endif
          begin
            w_cnt    = 3'd0;
            w_status = 2'b01;
            w_addr   = mem_data_addr;
            if (memory_vis_signal == 2'b01) begin
              w_state = S_READ;
              w_sig   = 2'b01;
            end else begin
              w_state = S_WRITE;
              w_sig   = 2'b10;
              w_wdat  = mem_write_data[BYTE_SIZE-1:0];
            end
          end
        end
      end
      S_READ: begin
        w_cnt = w_nxt;
        if (r_cnt == r_n) begin
          w_state  = S_DONE;
          w_status = 2'b10;
          w_rdata  = w_ext;
        end else begin
          w_status = 2'b01;
          if (w_nxt != r_n) begin
            w_sig  = 2'b01;
            w_addr = r_base + w_off;
          end
        end
      end
      S_WRITE: begin
        w_cnt = w_nxt;
        if (w_nxt == r_n) begin
          w_state  = S_DONE;
          w_status = 2'b10;
        end else begin
          w_status = 2'b01;
          w_sig    = 2'b10;
          w_addr   = r_base + w_off;
          w_wdat   = byte_of(r_wdata, w_nxt[1:0]);
        end
      end
      S_DONE:  w_state = S_IDLE;
      S_ERR:   w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= 3'd0;
      r_n            <= 3'd1;
      r_base         <= '0;
      r_wdata        <= '0;
      r_rbuf         <= '0;
      r_sext         <= 1'b0;
      mem_read_data  <= '0;
      mem_vis_status <= 2'b00;
      mem_vis_addr   <= '0;
      mem_vis_signal <= 2'b00;
      writen_data    <= '0;
    end else begin
      r_state        <= w_state;
      r_cnt          <= w_cnt;
      mem_read_data  <= w_rdata;
      mem_vis_status <= w_status;
      mem_vis_addr   <= w_addr;
      mem_vis_signal <= w_sig;
      writen_data    <= w_wdat;
      if (r_state == S_READ)
        r_rbuf <= w_rbuf;
      if (r_state == S_IDLE && w_acc) begin
        r_base  <= mem_data_addr;
        r_wdata <= mem_write_data;
        r_n     <= w_nin;
        r_sext  <= mem_sign_ext;
        r_rbuf  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench with a byte-array memory and a
// request-level reference model of the load/store serialiser.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_vis_enabled;
  logic [1:0]  memory_vis_signal;
  logic [1:0]  mem_size;
  logic        mem_sign_ext;
  logic [16:0] mem_data_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [1:0]  mem_vis_status;
  logic [16:0] mem_vis_addr;
  logic [1:0]  mem_vis_signal;
  logic [7:0]  writen_data;
  bit   [7:0]  mem_data;

  data_mem_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem_vis_enabled   (mem_vis_enabled),
    .memory_vis_signal (memory_vis_signal),
    .mem_size          (mem_size),
    .mem_sign_ext      (mem_sign_ext),
    .mem_data_addr     (mem_data_addr),
    .mem_write_data    (mem_write_data),
    .mem_read_data     (mem_read_data),
    .mem_vis_status    (mem_vis_status),
    .mem_vis_addr      (mem_vis_addr),
    .mem_vis_signal    (mem_vis_signal),
    .writen_data       (writen_data),
    .mem_data          (mem_data)
  );

  typedef struct {
    logic [1:0]  sig;
    logic [16:0] addr;
    logic [7:0]  dat;
  } bus_t;

  typedef struct {
    logic [1:0]  st;
    int          lat;
    logic [31:0] rd;
    int          start;
  } done_t;

  bus_t        bq[$];
  done_t       dq[$];
  bus_t        be;
  done_t       de;
  bit   [7:0]  mem     [0:131071];
  bit   [7:0]  ref_mem [0:131071];
  int          errs   = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [31:0] last_rd = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  // byte-wide main memory: writes commit, reads answer next cycle
  always @(posedge clk) begin
    if (mem_vis_signal == 2'b10)
      mem[mem_vis_addr] <= writen_data;
    else if (mem_vis_signal == 2'b01)
      mem_data <= mem[mem_vis_addr];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_vis_signal != 2'b00) begin
          chk("busy_status", {30'd0, mem_vis_status}, 32'd1);
          if (bq.size() == 0) begin
            chk("bus_unexpected", {30'd0, mem_vis_signal}, 32'd0);
          end else begin
            be = bq.pop_front();
            chk("bus_sig", {30'd0, mem_vis_signal}, {30'd0, be.sig});
            chk("bus_addr", {15'd0, mem_vis_addr}, {15'd0, be.addr});
            if (be.sig == 2'b10)
              chk("bus_wdat", {24'd0, writen_data}, {24'd0, be.dat});
          end
        end
        if (mem_vis_status[1]) begin
          if (dq.size() == 0) begin
            chk("done_unexpected", {30'd0, mem_vis_status}, 32'd0);
          end else begin
            de = dq.pop_front();
            chk("done_status", {30'd0, mem_vis_status}, {30'd0, de.st});
            chk("done_latency", cyc - de.start, de.lat);
            chk("read_data", mem_read_data, de.rd);
          end
        end
      end
    end
  end

  task automatic req(input bit wr, input logic [1:0] sz,
                     input bit sx, input logic [16:0] a,
                     input logic [31:0] wd);
    int          n;
    int          start;
    bit          err;
    bit          seen;
    logic [16:0] aj;
    longint      v;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    err = 1'b0;
`ifdef DATA_MEM_MISALIGN_CHK_EN
    err = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`endif
    @(negedge clk);
    mem_vis_enabled   = 1'b1;
    memory_vis_signal = wr ? 2'b10 : 2'b01;
    mem_size          = sz;
    mem_sign_ext      = sx;
    mem_data_addr     = a;
    mem_write_data    = wd;
    start = cyc;
    if (err) begin
      dq.push_back('{st: 2'b11, lat: 1, rd: last_rd, start: start});
    end else begin
      v = 0;
      for (int j = 0; j < n; j++) begin
        aj = a + 17'(j);
        if (wr) begin
          bq.push_back('{sig: 2'b10, addr: aj, dat: wd[8*j +: 8]});
          ref_mem[aj] = wd[8*j +: 8];
        end else begin
          bq.push_back('{sig: 2'b01, addr: aj, dat: 8'h00});
          v = v + (longint'(ref_mem[aj]) << (8*j));
        end
      end
      if (wr) begin
        dq.push_back('{st: 2'b10, lat: n + 1, rd: last_rd, start: start});
      end else begin
        if (n < 4 && sx && v >= (64'd1 << (8*n - 1)))
          v = v - (64'd1 << (8*n));
        last_rd = 32'(v);
        dq.push_back('{st: 2'b10, lat: n + 2, rd: last_rd, start: start});
      end
    end
    @(posedge clk);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (mem_vis_status[1]) seen = 1'b1;
      else begin
        mem_data_addr  = 17'($urandom);
        mem_write_data = $urandom;
        mem_size       = 2'($urandom);
        mem_sign_ext   = 1'($urandom);
      end
    end
    mem_vis_enabled   = 1'b0;
    memory_vis_signal = 2'b00;
    if (!seen) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_status"}, {30'd0, mem_vis_status}, 32'd0);
    chk({nm, "_sig"}, {30'd0, mem_vis_signal}, 32'd0);
    chk({nm, "_addr"}, {15'd0, mem_vis_addr}, 32'd0);
    chk({nm, "_wdat"}, {24'd0, writen_data}, 32'd0);
    chk({nm, "_rdata"}, mem_read_data, 32'd0);
  endtask

  initial begin
    rst_n             = 1'b0;
    mem_vis_enabled   = 1'b0;
    memory_vis_signal = 2'b00;
    mem_size          = 2'b00;
    mem_sign_ext      = 1'b0;
    mem_data_addr     = '0;
    mem_write_data    = '0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    req(1'b1, 2'b10, 1'b0, 17'h00100, 32'hDEADBEEF);
    chk("t1_mem", {mem[17'h103], mem[17'h102],
                   mem[17'h101], mem[17'h100]}, 32'hDEADBEEF);
    req(1'b0, 2'b10, 1'b0, 17'h00100, 32'h0);
    chk("t2_rd", mem_read_data, 32'hDEADBEEF);
    req(1'b0, 2'b00, 1'b1, 17'h00103, 32'h0);
    chk("t3_sb", mem_read_data, 32'hFFFFFFDE);
    req(1'b0, 2'b00, 1'b0, 17'h00103, 32'h0);
    chk("t3_ub", mem_read_data, 32'h000000DE);
    req(1'b0, 2'b01, 1'b1, 17'h00102, 32'h0);
    chk("t3_sh", mem_read_data, 32'hFFFFDEAD);
    req(1'b1, 2'b11, 1'b0, 17'h1FFFF, 32'h11223344);
    chk("t4_wrap", {mem[17'h00002], mem[17'h00001],
                    mem[17'h00000], mem[17'h1FFFF]}, 32'h11223344);
    req(1'b0, 2'b01, 1'b0, 17'h00101, 32'h0);

    // reset lands after two bytes of a word store have been written
    @(negedge clk);
    mem_vis_enabled   = 1'b1;
    memory_vis_signal = 2'b10;
    mem_size          = 2'b10;
    mem_data_addr     = 17'h00200;
    mem_write_data    = 32'hCAFEF00D;
    bq.push_back('{sig: 2'b10, addr: 17'h00200, dat: 8'h0D});
    bq.push_back('{sig: 2'b10, addr: 17'h00201, dat: 8'hF0});
    ref_mem[17'h00200] = 8'h0D;
    ref_mem[17'h00201] = 8'hF0;
    repeat (3) @(posedge clk);
    #1;
    rst_n           = 1'b0;
    mem_vis_enabled = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    last_rd = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_partial", {8'd0, mem[17'h202], mem[17'h201], mem[17'h200]},
        32'h0000F00D);
    req(1'b0, 2'b00, 1'b0, 17'h00201, 32'h0);
    req(1'b0, 2'b00, 1'b0, 17'h00202, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic [16:0] ra;
      ra = ($urandom_range(0, 1) == 0)
         ? 17'h1FFF8 + 17'($urandom_range(0, 15))
         : 17'h00400 + 17'($urandom_range(0, 15));
      req(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom);
    end

    repeat (5) @(negedge clk);
    chk("bus_queue_empty", bq.size(), 32'd0);
    chk("done_queue_empty", dq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
